// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter that sequences one-word accesses
// to a byte-addressed big-endian data memory, with Ack/Err responses.
module dmem_arbiter #(
    parameter int MEM_BYTES = 61,
    parameter int ADDR_W    = 32
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Req0,
    input  logic              Wr0,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [31:0]       WData0,
    output logic              Ack0,
    output logic              Err0,
    output logic [31:0]       RData0,
    input  logic              Req1,
    input  logic              Wr1,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [31:0]       WData1,
    output logic              Ack1,
    output logic              Err1,
    output logic [31:0]       RData1,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [31:0]       MemDataIn,
    input  logic [31:0]       MemDataOut,
    output logic              MemRD,
    output logic              MemWR,
    output logic              Busy
);
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t            state_q, state_d;
    logic              owner_q, owner_d, last_q, last_d, wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              ack0_q, ack0_d, ack1_q, ack1_d, err0_q, err0_d, err1_q, err1_d;
    logic              elig0, elig1, win, legal;
    logic [ADDR_W-1:0] win_addr;
    logic [ADDR_W:0]   win_end;
    always_comb begin
        // a request still held while its own response is visible is stale
        elig0    = Req0 & ~ack0_q & ~err0_q;
        elig1    = Req1 & ~ack1_q & ~err1_q;
        win      = (elig0 & elig1) ? ~last_q : elig1;
        win_addr = win ? Addr1 : Addr0;
        win_end  = {1'b0, win_addr} + (ADDR_W+1)'(3);
        legal    = (win_addr[1:0] == 2'b00) && (win_end <= (ADDR_W+1)'(MEM_BYTES - 1));
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        addr_d   = addr_q;
        wr_d     = wr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        err0_d   = 1'b0;
        err1_d   = 1'b0;
        if (state_q == ACCESS) begin
            state_d  = IDLE;
            ack0_d   = ~owner_q;
            ack1_d   = owner_q;
            rdata0_d = (~owner_q & ~wr_q) ? MemDataOut : rdata0_q;
            rdata1_d = (owner_q & ~wr_q) ? MemDataOut : rdata1_q;
        end else if (elig0 | elig1) begin
            owner_d = win;
            last_d  = win;
            err0_d  = ~legal & ~win;
            err1_d  = ~legal & win;
            // memory-side registers only move on a legal grant so they hold otherwise
            if (legal) begin
                state_d = ACCESS;
                addr_d  = win_addr;
                wr_d    = win ? Wr1 : Wr0;
                wdata_d = win ? WData1 : WData0;
            end
        end
    end
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
        end
    end
    // enables are an AND of flops only, so reset drops MemWR immediately
    assign Busy      = (state_q == ACCESS);
    assign MemRD     = Busy & ~wr_q;
    assign MemWR     = Busy & wr_q;
    assign MemAddr   = addr_q;
    assign MemDataIn = wdata_q;
    assign Ack0      = ack0_q;
    assign Ack1      = ack1_q;
    assign Err0      = err0_q;
    assign Err1      = err1_q;
    assign RData0    = rdata0_q;
    assign RData1    = rdata1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a
// transaction-level scoreboard and a byte-array memory.
module tb_dmem_arbiter;
    logic             clk, rst_n;
    logic [1:0]       req, wr, ack, err;
    logic [1:0][31:0] addr, wd, rd;
    logic [31:0]      mem_addr, mem_din, mem_out;
    logic             mem_rd, mem_wr, busy;
    logic [7:0]       dev [0:60];
    logic [7:0]       ref_m [0:60];
    bit               preload = 1'b1;
    int               ma, n_chk, n_fail, rd_cyc, wr_cyc;
    int               age [2];
    int               hold [2];
    bit               pend [2];
    bit               pwr [2];
    bit               bounce [2];
    logic [31:0]      paddr [2];
    logic [31:0]      pwd [2];

    dmem_arbiter #(.MEM_BYTES(61), .ADDR_W(32)) dut (
        .CLK(clk), .Reset(rst_n),
        .Req0(req[0]), .Wr0(wr[0]), .Addr0(addr[0]), .WData0(wd[0]),
        .Ack0(ack[0]), .Err0(err[0]), .RData0(rd[0]),
        .Req1(req[1]), .Wr1(wr[1]), .Addr1(addr[1]), .WData1(wd[1]),
        .Ack1(ack[1]), .Err1(err[1]), .RData1(rd[1]),
        .MemAddr(mem_addr), .MemDataIn(mem_din), .MemDataOut(mem_out),
        .MemRD(mem_rd), .MemWR(mem_wr), .Busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pat(int i);
        return i == 8 ? 8'h12 : i == 9 ? 8'h34 : i == 10 ? 8'h56 : i == 11 ? 8'h78 : 8'(i * 7 + 3);
    endfunction

    always @(negedge clk) begin
        if (preload) begin
            for (int i = 0; i < 61; i++) dev[i] <= pat(i);
        end else if (mem_wr && mem_addr <= 32'd57) begin
            dev[int'(mem_addr)]     <= mem_din[31:24];
            dev[int'(mem_addr) + 1] <= mem_din[23:16];
            dev[int'(mem_addr) + 2] <= mem_din[15:8];
            dev[int'(mem_addr) + 3] <= mem_din[7:0];
        end
    end

    always_comb begin
        ma      = int'(mem_addr[5:0]);
        mem_out = (mem_addr <= 32'd57) ? {dev[ma], dev[ma + 1], dev[ma + 2], dev[ma + 3]} : 32'd0;
    end

    function automatic bit legal(logic [31:0] a);
        return (a % 4 == 0) && ({32'd0, a} + 64'd3 <= 64'd60);
    endfunction

    function automatic logic [31:0] rword(int a);
        return {ref_m[a], ref_m[a + 1], ref_m[a + 2], ref_m[a + 3]};
    endfunction

    function automatic logic [31:0] dword(int a);
        return {dev[a], dev[a + 1], dev[a + 2], dev[a + 3]};
    endfunction

    function automatic logic [31:0] rnd_addr();
        int r = $urandom_range(7);
        return r == 0 ? 32'($urandom_range(63)) : r == 1 ? 32'hFFFF_FFFC :
               r == 2 ? 32'd56 : 32'($urandom_range(15) * 4);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic arm(input int p, input bit w, input logic [31:0] a, input logic [31:0] d);
        req[p] = 1'b1; wr[p] = w; addr[p] = a; wd[p] = d;
        pend[p] = 1'b1; pwr[p] = w; paddr[p] = a; pwd[p] = d; age[p] = 0;
    endtask

    // one clock: sample just after the edge, score responses, update request lines
    task automatic step();
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++)
            if (bounce[p]) begin
                bounce[p] = 1'b0;
                arm(p, pwr[p], paddr[p], pwd[p]);
            end
        chk("one_resp", 64'($countones({ack, err}) <= 1), 1);
        chk("rd_wr_excl", mem_rd & mem_wr, 0);
        chk("en_busy", (mem_rd | mem_wr) & ~busy, 0);
        if (mem_rd) rd_cyc++;
        if (mem_wr) wr_cyc++;
        for (int p = 0; p < 2; p++) begin
            if (ack[p] | err[p]) begin
                chk("resp_pend", pend[p], 1);
                if (pend[p]) begin
                    chk("resp_kind", ack[p], legal(paddr[p]));
                    if (ack[p] && !pwr[p]) chk("rdata", rd[p], rword(int'(paddr[p])));
                    if (ack[p] && pwr[p]) begin
                        ref_m[int'(paddr[p])]     = pwd[p][31:24];
                        ref_m[int'(paddr[p]) + 1] = pwd[p][23:16];
                        ref_m[int'(paddr[p]) + 2] = pwd[p][15:8];
                        ref_m[int'(paddr[p]) + 3] = pwd[p][7:0];
                    end
                end
                pend[p] = 1'b0;
                if (hold[p] == 1) begin
                    pend[p] = 1'b1;
                    age[p] = 0;
                end else begin
                    req[p] = 1'b0;
                    bounce[p] = (hold[p] == 2);
                end
            end else if (pend[p]) begin
                age[p]++;
                if (age[p] > 8) begin
                    chk("timeout", age[p], 8);
                    pend[p] = 1'b0;
                    req[p] = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_idle(input int p);
        for (int i = 0; i < 12 && pend[p]; i++) step();
    endtask

    task automatic run(input int p, input bit w, input logic [31:0] a, input logic [31:0] d);
        int r0, w0, lat;
        step();
        r0 = rd_cyc; w0 = wr_cyc; lat = 0;
        arm(p, w, a, d);
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            step();
            if (!pend[p]) lat = i;
        end
        chk("latency", lat, legal(a) ? 2 : 1);
        chk("rd_cycles", rd_cyc - r0, (legal(a) && !w) ? 1 : 0);
        chk("wr_cycles", wr_cyc - w0, (legal(a) && w) ? 1 : 0);
    endtask

    initial begin
        rst_n = 1'b0; req = '0; wr = '0; addr = '0; wd = '0;
        for (int p = 0; p < 2; p++) begin
            age[p] = 0; hold[p] = 0; pend[p] = 0; bounce[p] = 0; pwr[p] = 0; paddr[p] = 0; pwd[p] = 0;
        end
        for (int i = 0; i < 61; i++) ref_m[i] = pat(i);
        step();
        step();
        preload = 1'b0;
        chk("rst_resp", {ack, err}, 0);
        chk("rst_rdata", rd, 0);
        chk("rst_mem", {mem_rd, mem_wr, busy}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_din", mem_din, 0);
        rst_n = 1'b1;
        run(0, 1'b0, 32'd8, 32'd0);
        chk("rd8", rd[0], 32'h12345678);
        chk("ack1_quiet", ack[1], 0);
        run(1, 1'b1, 32'd16, 32'hDEADBEEF);
        chk("wr16_bytes", dword(16), 32'hDEADBEEF);
        run(1, 1'b0, 32'd16, 32'd0);
        chk("rd16", rd[1], 32'hDEADBEEF);
        run(0, 1'b0, 32'd6, 32'd0);
        run(0, 1'b1, 32'd58, 32'h11111111);
        run(0, 1'b1, 32'd60, 32'h22222222);
        run(1, 1'b0, 32'hFFFF_FFFC, 32'd0);
        run(1, 1'b1, 32'd56, 32'h0BADF00D);
        chk("wr56_bytes", dword(56), 32'h0BADF00D);
        // request held across its own Ack must not be re-granted while Ack is high
        step();
        hold[0] = 1;
        arm(0, 1'b0, 32'd12, 32'd0);
        for (int i = 0; i < 6 && !ack[0]; i++) step();
        chk("stale_ack", ack[0], 1);
        step();
        chk("stale_idle", {busy, ack[0]}, 0);
        step();
        chk("stale_regrant", busy, 1);
        hold[0] = 0;
        wait_idle(0);
        // contention from reset: requester 0 wins the first tie, then strict alternation
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        hold[0] = 2; hold[1] = 2;
        arm(0, 1'b0, 32'd24, 32'd0);
        arm(1, 1'b0, 32'd28, 32'd0);
        for (int s = 1; s <= 8; s++) begin
            step();
            chk("cont_ack", ack, (s % 4 == 2) ? 2'b01 : (s % 4 == 0) ? 2'b10 : 2'b00);
        end
        hold[0] = 0; hold[1] = 0;
        if (bounce[1]) begin
            bounce[1] = 1'b0;
            req[1] = 1'b0;
        end
        wait_idle(0);
        wait_idle(1);
        step();
        step();
        // reset during a write access, before the memory's negedge write
        req[1] = 1'b1; wr[1] = 1'b1; addr[1] = 32'd20; wd[1] = 32'hCAFEF00D;
        step();
        chk("mid_busy", {busy, mem_wr}, 2'b11);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_en", {mem_wr, mem_rd, busy}, 0);
        chk("mid_rst_resp", {ack, err}, 0);
        chk("mid_rst_rdata", rd, 0);
        chk("mid_rst_addr", {mem_addr, mem_din}, 0);
        req[1] = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("mid_no_ack", ack, 0);
        chk("mid_bytes", dword(20), rword(20));
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++)
                if (!pend[p] && $urandom_range(2) == 0) arm(p, 1'($urandom_range(1)), rnd_addr(), $urandom());
            step();
        end
        wait_idle(0);
        wait_idle(1);
        for (int i = 0; i < 61; i += 4) chk("final_mem", dev[i], ref_m[i]);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
